// File: rtl/lsu_load_wb_pkg.sv
// Shared widths, load funct3 encodings, exception codes and the pending-load entry type
// for the load writeback stage.
package lsu_load_wb_pkg;

  localparam int unsigned RF_IDX_WIDTH = 5;
  localparam int unsigned rv32_XLEN    = 32;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  localparam logic [1:0] LD_EXC_MISALIGN = 2'b01;
  localparam logic [1:0] LD_EXC_ILLEGAL  = 2'b10;
  localparam logic [1:0] LD_EXC_BUSERR   = 2'b11;

  typedef struct packed {
    logic [RF_IDX_WIDTH-1:0] rd;
    logic [2:0]              funct3;
    logic [1:0]              off;
  } pend_t;

  function automatic logic ld_funct3_illegal(input logic [2:0] funct3);
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

  function automatic logic ld_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    return (((funct3 == LD_LH) || (funct3 == LD_LHU)) && off[0]) ||
           ((funct3 == LD_LW) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/ld_data_align.sv
// Selects the addressed byte/halfword of a returned word and sign- or zero-extends it.
module ld_data_align
  import lsu_load_wb_pkg::*;
(
  input  logic [rv32_XLEN-1:0] word_i,
  input  logic [2:0]           funct3_i,
  input  logic [1:0]           off_i,
  output logic [rv32_XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data_o = {24'h0, byte_sel};
      LD_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data_o = {16'h0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_load_wb.sv
// Load writeback stage: issues word-aligned reads, tracks in-order outstanding loads and
// writes aligned response data to the register file one cycle after each response.
module lsu_load_wb
  import lsu_load_wb_pkg::*;
#(
  parameter int unsigned OSTD_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld_req_valid,
  output logic                    ld_req_ready,
  input  logic [31:0]             ld_req_addr,
  input  logic [2:0]              ld_req_funct3,
  input  logic [RF_IDX_WIDTH-1:0] ld_req_rd,
  output logic                    mem_cmd_valid,
  input  logic                    mem_cmd_ready,
  output logic [31:0]             mem_cmd_addr,
  input  logic                    mem_rsp_valid,
  input  logic [rv32_XLEN-1:0]    mem_rsp_data,
  input  logic                    mem_rsp_err,
  output logic                    Men_wb,
  output logic [RF_IDX_WIDTH-1:0] Mrd_wb,
  output logic [rv32_XLEN-1:0]    Mdata_wb,
  output logic                    ld_busy,
  output logic [1:0]              ld_exc
);

  localparam int unsigned PtrW = (OSTD_DEPTH > 1) ? $clog2(OSTD_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(OSTD_DEPTH + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(OSTD_DEPTH - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(OSTD_DEPTH);

  pend_t fifo_q [OSTD_DEPTH];
  pend_t head, push_entry;

  logic                    cmd_vld_q, cmd_vld_d;
  logic [31:0]             cmd_addr_q, cmd_addr_d;
  logic [PtrW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    wb_en_q, wb_en_d;
  logic [RF_IDX_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic [rv32_XLEN-1:0]    wb_data_q, wb_data_d;
  logic [1:0]              exc_q, exc_d;

  logic                 req_acc, req_ill, req_mis, push, pop;
  logic [rv32_XLEN-1:0] aligned;

  assign ld_req_ready = ~cmd_vld_q & (cnt_q < CntMax);

  ld_data_align u_align (
    .word_i   (mem_rsp_data),
    .funct3_i (head.funct3),
    .off_i    (head.off),
    .data_o   (aligned)
  );

  always_comb begin
    req_acc = ld_req_valid & ld_req_ready;
    req_ill = ld_funct3_illegal(ld_req_funct3);
    req_mis = ld_misaligned(ld_req_funct3, ld_req_addr[1:0]);
    push    = req_acc & ~req_ill & ~req_mis;
    // Responses with nothing pending are stray and must not touch state.
    pop     = mem_rsp_valid & (cnt_q != '0);
    head    = fifo_q[rptr_q];

    push_entry = '{rd: ld_req_rd, funct3: ld_req_funct3, off: ld_req_addr[1:0]};

    cmd_vld_d  = cmd_vld_q;
    cmd_addr_d = cmd_addr_q;
    if (cmd_vld_q && mem_cmd_ready) cmd_vld_d = 1'b0;
    if (push) begin
      cmd_vld_d  = 1'b1;
      cmd_addr_d = {ld_req_addr[31:2], 2'b00};
    end

    wptr_d = wptr_q;
    if (push) wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + 1'b1;
    rptr_d = rptr_q;
    if (pop) rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + 1'b1;

    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;

    wb_en_d   = pop & ~mem_rsp_err & (head.rd != '0);
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (wb_en_d) begin
      wb_rd_d   = head.rd;
      wb_data_d = aligned;
    end

    // A bus error outranks a simultaneous request fault, which is then dropped.
    if (pop && mem_rsp_err)   exc_d = LD_EXC_BUSERR;
    else if (req_acc && req_ill) exc_d = LD_EXC_ILLEGAL;
    else if (req_acc && req_mis) exc_d = LD_EXC_MISALIGN;
    else                         exc_d = 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_vld_q  <= 1'b0;
      cmd_addr_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      wb_en_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      exc_q      <= 2'b00;
    end else begin
      cmd_vld_q  <= cmd_vld_d;
      cmd_addr_q <= cmd_addr_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      wb_en_q    <= wb_en_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      exc_q      <= exc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(OSTD_DEPTH); i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wptr_q] <= push_entry;
    end
  end

  assign mem_cmd_valid = cmd_vld_q;
  assign mem_cmd_addr  = cmd_addr_q;
  assign Men_wb        = wb_en_q;
  assign Mrd_wb        = wb_rd_q;
  assign Mdata_wb      = wb_data_q;
  assign ld_busy       = cmd_vld_q | (cnt_q != '0);
  assign ld_exc        = exc_q;

endmodule

// File: tb/tb_lsu_load_wb.sv
// Directed and randomized checks of lsu_load_wb against a queue-based reference model.
module tb_lsu_load_wb;
  import lsu_load_wb_pkg::*;

  localparam int unsigned Depth = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_req_valid, ld_req_ready;
  logic [31:0] ld_req_addr;
  logic [2:0]  ld_req_funct3;
  logic [4:0]  ld_req_rd;
  logic        mem_cmd_valid, mem_cmd_ready;
  logic [31:0] mem_cmd_addr;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_data;
  logic        Men_wb;
  logic [4:0]  Mrd_wb;
  logic [31:0] Mdata_wb;
  logic        ld_busy;
  logic [1:0]  ld_exc;

  always #5 clk = ~clk;

  lsu_load_wb #(.OSTD_DEPTH(Depth)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ld_req_valid  (ld_req_valid),
    .ld_req_ready  (ld_req_ready),
    .ld_req_addr   (ld_req_addr),
    .ld_req_funct3 (ld_req_funct3),
    .ld_req_rd     (ld_req_rd),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_cmd_addr  (mem_cmd_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .Men_wb        (Men_wb),
    .Mrd_wb        (Mrd_wb),
    .Mdata_wb      (Mdata_wb),
    .ld_busy       (ld_busy),
    .ld_exc        (ld_exc)
  );

  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] off;
  } ld_t;

  // Reference model: loads accepted but not yet written back, plus bus-side bookkeeping.
  ld_t         pend[$];
  bit          m_cmd;
  logic [31:0] m_cmd_addr;
  int          bus_out;
  logic        m_men;
  logic [4:0]  m_mrd;
  logic [31:0] m_mdata;
  logic [1:0]  m_exc;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  function automatic bit is_ill(input logic [2:0] f);
    return (f == 3'd3) || (f == 3'd6) || (f == 3'd7);
  endfunction

  function automatic bit is_mis(input logic [2:0] f, input logic [1:0] off);
    return ((f == LD_LH || f == LD_LHU) && off[0]) || (f == LD_LW && off != 2'd0);
  endfunction

  function automatic logic [31:0] ref_align(input logic [31:0] w, input logic [2:0] f,
                                            input logic [1:0] off);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f)
      LD_LB:   return (b >= 128) ? b - 32'd256 : b;
      LD_LBU:  return b;
      LD_LH:   return (h >= 32768) ? h - 32'd65536 : h;
      LD_LHU:  return h;
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    pend.delete();
    m_cmd      = 1'b0;
    m_cmd_addr = '0;
    bus_out    = 0;
    m_men      = 1'b0;
    m_mrd      = '0;
    m_mdata    = '0;
    m_exc      = 2'b00;
  endtask

  task automatic check_outputs();
    chk("ld_req_ready", ld_req_ready, !m_cmd && pend.size() < Depth);
    chk("mem_cmd_valid", mem_cmd_valid, m_cmd);
    if (m_cmd) chk("mem_cmd_addr", mem_cmd_addr, m_cmd_addr);
    chk("Men_wb", Men_wb, m_men);
    chk("Mrd_wb", Mrd_wb, m_mrd);
    chk("Mdata_wb", Mdata_wb, m_mdata);
    chk("ld_exc", ld_exc, m_exc);
    chk("ld_busy", ld_busy, m_cmd || pend.size() != 0);
  endtask

  // One clock: check current outputs, apply inputs, advance the model, cross the edge.
  task automatic cyc(input bit v, input logic [31:0] a, input logic [2:0] f, input logic [4:0] r,
                     input bit cr, input bit rv, input logic [31:0] d, input bit e);
    bit  acc;
    ld_t h;
    check_outputs();
    ld_req_valid  = v;
    ld_req_addr   = a;
    ld_req_funct3 = f;
    ld_req_rd     = r;
    mem_cmd_ready = cr;
    mem_rsp_valid = rv;
    mem_rsp_data  = d;
    mem_rsp_err   = e;

    acc   = v && !m_cmd && pend.size() < Depth;
    m_men = 1'b0;
    m_exc = 2'b00;
    if (rv && pend.size() > 0) begin
      h = pend.pop_front();
      if (bus_out > 0) bus_out--;
      if (e) m_exc = 2'b11;
      else if (h.rd != 0) begin
        m_men   = 1'b1;
        m_mrd   = h.rd;
        m_mdata = ref_align(d, h.f3, h.off);
      end
    end
    if (acc && m_exc == 2'b00) begin
      if (is_ill(f))             m_exc = 2'b10;
      else if (is_mis(f, a[1:0])) m_exc = 2'b01;
    end
    if (m_cmd && cr) begin
      m_cmd = 1'b0;
      bus_out++;
    end
    if (acc && !is_ill(f) && !is_mis(f, a[1:0])) begin
      pend.push_back('{rd: r, f3: f, off: a[1:0]});
      m_cmd      = 1'b1;
      m_cmd_addr = a & ~32'h3;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic one_load(input logic [31:0] a, input logic [2:0] f, input logic [4:0] r,
                          input logic [31:0] d, input bit e);
    cyc(1, a, f, r, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, d, e);
  endtask

  logic [2:0]  legal_f3 [5] = '{LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU};
  logic [31:0] r_addr;
  logic [2:0]  r_f3;

  initial begin
    rst_n = 1'b0;
    ld_req_valid = 0; ld_req_addr = 0; ld_req_funct3 = 0; ld_req_rd = 0;
    mem_cmd_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0; mem_rsp_err = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("rst_cmd_addr", mem_cmd_addr, 32'h0);
    rst_n = 1'b1;
    idle();

    // LW to rd 5: command one cycle after accept, writeback one cycle after response.
    cyc(1, 32'h100, LD_LW, 5, 0, 0, 0, 0);
    chk("lw_cmd_valid", mem_cmd_valid, 1);
    chk("lw_cmd_addr", mem_cmd_addr, 32'h100);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
    chk("lw_men", Men_wb, 1);
    chk("lw_mrd", Mrd_wb, 5);
    chk("lw_mdata", Mdata_wb, 32'hDEADBEEF);
    idle();

    one_load(32'h103, LD_LB, 7, 32'h80FF7F01, 0);
    chk("lb_mdata", Mdata_wb, 32'hFFFFFF80);
    one_load(32'h103, LD_LBU, 7, 32'h80FF7F01, 0);
    chk("lbu_mdata", Mdata_wb, 32'h00000080);
    idle();

    // Illegal requests: accepted, but no command and only an exception pulse.
    cyc(1, 32'h101, LD_LH, 6, 0, 0, 0, 0);
    chk("mis_exc", ld_exc, 2'b01);
    chk("mis_no_cmd", mem_cmd_valid, 0);
    chk("mis_not_busy", ld_busy, 0);
    idle();
    cyc(1, 32'h100, 3'b011, 6, 0, 0, 0, 0);
    chk("ill_exc", ld_exc, 2'b10);
    idle();

    // Two LWs with a stalled bus; third request waits for the first pop.
    cyc(1, 32'h200, LD_LW, 3, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 32'h204, LD_LW, 4, 0, 0, 0, 0);
    chk("two_busy", ld_busy, 1);
    cyc(1, 32'h208, LD_LW, 9, 1, 0, 0, 0);
    chk("full_not_ready", ld_req_ready, 0);
    cyc(1, 32'h208, LD_LW, 9, 0, 1, 32'h11111111, 0);
    chk("first_wb_rd", Mrd_wb, 3);
    cyc(1, 32'h208, LD_LW, 9, 0, 1, 32'h22222222, 0);
    chk("second_wb_rd", Mrd_wb, 4);
    chk("third_accepted", mem_cmd_valid, 1);
    chk("third_addr", mem_cmd_addr, 32'h208);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h33333333, 0);
    idle();

    one_load(32'h300, LD_LW, 8, 32'h12345678, 1);
    chk("buserr_men", Men_wb, 0);
    chk("buserr_exc", ld_exc, 2'b11);
    one_load(32'h304, LD_LW, 0, 32'h87654321, 0);
    chk("rd0_men", Men_wb, 0);
    chk("rd0_idle", ld_busy, 0);
    idle();

    // Reset with two loads pending and a command in flight.
    cyc(1, 32'h400, LD_LW, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 32'h404, LD_LW, 4, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("midrst_cmd_addr", mem_cmd_addr, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0);
    chk("late_rsp_men", Men_wb, 0);
    idle();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) r_f3 = 3'($urandom_range(0, 7));
      else r_f3 = legal_f3[$urandom_range(0, 4)];
      r_addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (r_f3 == LD_LW) r_addr[1:0] = 2'b00;
        if (r_f3 == LD_LH || r_f3 == LD_LHU) r_addr[0] = 1'b0;
      end
      cyc($urandom_range(0, 1) == 1, r_addr, r_f3, 5'($urandom_range(0, 31)),
          $urandom_range(0, 2) != 0, bus_out > 0 && $urandom_range(0, 2) != 0,
          $urandom, $urandom_range(0, 9) == 0);
    end
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, bus_out > 0, $urandom, 0);
    idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lsu_load_wb.md
# lsu_load_wb

Load-response writeback stage directly upstream of the register file's memory write port. Accepts load requests from EX, issues word-aligned read commands on the data bus, tracks up to `OSTD_DEPTH` in-order outstanding loads, and aligns and extends the returned data. It drives the register file's `Men_wb` / `Mrd_wb` / `Mdata_wb` write port one cycle after each response.

## Interface
- `OSTD_DEPTH`, default 2: maximum accepted-but-not-written-back loads (1..4).
- `clk`  in  1  clock. One clock domain; everything is on the rising edge.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `ld_req_valid`  in  1  EX presents a load.
- `ld_req_ready`  out  1  load is accepted when both `ld_req_valid` and `ld_req_ready` are 1.
- `ld_req_addr`  in  32  byte address.
- `ld_req_funct3`  in  3  load funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- `ld_req_rd`  in  `RF_IDX_WIDTH`  destination register.
- `mem_cmd_valid`  out  1  read command valid.
- `mem_cmd_ready`  in  1  bus accepts the command.
- `mem_cmd_addr`  out  32  word address, `{ld_req_addr[31:2], 2'b00}`.
- `mem_rsp_valid`  in  1  in-order read response.
- `mem_rsp_data`  in  `rv32_XLEN`  returned word.
- `mem_rsp_err`  in  1  bus error, qualified by `mem_rsp_valid`.
- `Men_wb`  out  1  register file write enable.
- `Mrd_wb`  out  `RF_IDX_WIDTH`  register file write index.
- `Mdata_wb`  out  `rv32_XLEN`  register file write data.
- `ld_busy`  out  1  high when `cmd_vld` is 1 or `cnt` is non-zero; ID uses it as a load stall.
- `ld_exc`  out  2  one-cycle exception code: 01 misaligned, 10 illegal funct3, 11 bus error.

## Operation
- **State**
  - `cmd_vld`: command register holding the word address.
  - Pending FIFO of `OSTD_DEPTH` entries, each `{rd, funct3, addr[1:0]}`, with read and write pointers.
  - `cnt`: pending-entry count.
- **Request acceptance**
  - `ld_req_ready = ~cmd_vld & (cnt < OSTD_DEPTH)`.
  - A legal accepted request pushes one FIFO entry, loads the command register, and sets `cmd_vld`.
- **Illegal requests**
  - Misaligned: LH/LHU with `addr[0]=1`, or LW with `addr[1:0]!=0`.
  - Illegal funct3: 011, 110 or 111.
  - An illegal request is still accepted, but produces no command and no FIFO push.
  - `ld_exc` pulses the next cycle. Illegal funct3 takes priority over misaligned.
- **Command**
  - `mem_cmd_valid = cmd_vld`.
  - `cmd_vld` clears on the `mem_cmd_valid & mem_cmd_ready` handshake.
  - `mem_cmd_addr` holds stable while `mem_cmd_valid` is 1 and not accepted.
- **Response**
  - A response is consumed when `mem_rsp_valid` is 1 and `cnt` is non-zero; it pops the FIFO head.
  - A response arriving with `cnt==0` is ignored: no writeback, no state change.
- **Alignment** (shift by `addr[1:0]`)
  - LB/LBU take byte `addr[1:0]`, sign- or zero-extended to 32 bits.
  - LH/LHU take halfword `addr[1]`, sign- or zero-extended.
  - LW passes the word through.
- **Writeback**
  - Cycle after the pop: `Men_wb=1`, `Mrd_wb=head.rd`, `Mdata_wb`=aligned data.
  - If `head.rd==0`, or `mem_rsp_err=1`, then `Men_wb` stays 0.
  - A bus error instead pulses `ld_exc=11` in that cycle.
- **Counter update**
  - Push and pop in the same cycle leave `cnt` unchanged; pointers wrap modulo `OSTD_DEPTH`.
- There is no flush. Squashing a load is the upstream's responsibility: it must not issue the request.

## Timing
- Reset values:
  - `ld_req_ready=1`, `mem_cmd_valid=0`, `mem_cmd_addr=0`.
  - `Men_wb=0`, `Mrd_wb=0`, `Mdata_wb=0`, `ld_busy=0`, `ld_exc=00`.
  - `cnt=0`, pointers 0.
- **Asserting reset mid-operation** drops all pending entries and the command immediately. Responses that arrive after reset release with `cnt==0` are ignored.
- **Latency:** accept at cycle N → `mem_cmd_valid` at N+1. Response consumed at cycle M → `Men_wb` at M+1.
- `Men_wb` is a single-cycle pulse per load. `Mrd_wb` and `Mdata_wb` hold their last values while `Men_wb=0`.
- **Throughput:** at most one accept per two cycles, because `ld_req_ready` is low while `cmd_vld` is set. Responses can be consumed every cycle.
- **Response timing:** a response in the same cycle as the command handshake is legal only for an earlier entry. In-order returns are required of the bus.
- `ld_exc` is high for exactly one cycle. If a response error and an illegal-request flag occur in the same cycle, the bus error (11) is reported and the request flag is dropped.

## Structure
- `RF_IDX_WIDTH` and `rv32_XLEN` come from `risc_v_defines.v`.
- Add `LD_EXC_MISALIGN`, `LD_EXC_ILLEGAL` and `LD_EXC_BUSERR` to that file, alongside funct3 constants `LD_LB` … `LD_LHU`.
- One combinational sub-module, `ld_data_align`: inputs word, `funct3`, `addr[1:0]`; output is the extended data.
- Registers use the existing `dffl` cell where an enable applies.

## Test plan
- LW at 0x100, bus returns 0xDEADBEEF, `rd=5` → command at N+1 with addr 0x100; `Men_wb=1`, `Mrd_wb=5`, `Mdata_wb=0xDEADBEEF` on the cycle after the response.
- LB at 0x103 and LBU at 0x103, word 0x80FF7F01 → LB gives 0xFFFFFF80, LBU gives 0x00000080.
- LH at 0x101 → no `mem_cmd_valid`, `ld_exc=01` for one cycle, `cnt` stays 0. Funct3=011 → `ld_exc=10`.
- Two LWs (`rd=3`, `rd=4`) with `mem_cmd_ready` held low for 3 cycles:
  - `ld_req_ready` goes low with `cnt=2`.
  - Responses arrive on back-to-back cycles.
  - Writebacks occur to 3 then 4 in order; a third request is accepted only after the first pop.
- Response with `mem_rsp_err=1` → `Men_wb=0`, `ld_exc=11`. LW to `rd=0` → no `Men_wb`, `cnt` decrements.
- `rst_n` asserted with `cnt=2` and `cmd_vld=1` → all outputs return to reset values; a late response produces no `Men_wb`.
